// File: rtl/mdio_master.sv
// MDIO management master: MDC generation, preamble + 32-bit frame shift-out,
// line release for read turnaround and 16-bit read-data capture.
module mdio_master #(
    parameter int CLK_DIV = 2,
    parameter int PRE_LEN = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] t_data,
    input  logic        mdio_in,
    output logic        busy,
    output logic        done,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    output logic        err,
    output logic        mdc,
    output logic        mdio_out,
    output logic        mdio_oe
);

    localparam int T  = 2 * CLK_DIV;
    localparam int N  = PRE_LEN + 32;
    localparam int DW = $clog2(CLK_DIV) + 1;
    localparam int BW = 7;

    localparam logic [DW-1:0] DIV_RISE = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_END  = DW'(T - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
    localparam logic [BW-1:0] PRE_END  = BW'(PRE_LEN);
    localparam logic [BW-1:0] TA_BIT   = BW'(PRE_LEN + 14);
    localparam logic [BW-1:0] DATA_BIT = BW'(PRE_LEN + 16);
    localparam logic          HAS_PRE  = (PRE_LEN > 0);

    typedef enum logic [1:0] {IDLE, PREAMBLE, FRAME} state_t;

    localparam state_t FIRST = HAS_PRE ? PREAMBLE : FRAME;

    state_t          state, state_next;
    logic [BW-1:0]   bit_cnt;
    logic [DW-1:0]   div_cnt;
    logic [31:0]     frame;
    logic            rd_type;
    logic [15:0]     shift;

    logic            legal, rd_in, accept, reject;
    logic            bit_end, mdc_rise, last_bit;
    logic            pre_next, next_bit, release_next;
    logic [BW-1:0]   bit_nxt;
    logic [4:0]      frame_idx;

    // ST/OP decode of the incoming request
    always_comb begin
        legal = 1'b0;
        rd_in = 1'b0;
        case (t_data[31:30])
            2'b01: begin
                legal = (t_data[29:28] == 2'b01) || (t_data[29:28] == 2'b10);
                rd_in = (t_data[29:28] == 2'b10);
            end
            2'b00: begin
                legal = 1'b1;
                rd_in = t_data[29];
            end
            default: ;
        endcase
    end

    assign busy     = (state != IDLE);
    assign accept   = start && !busy && legal;
    assign reject   = start && !busy && !legal;
    assign bit_end  = (div_cnt == DIV_END);
    assign mdc_rise = (div_cnt == DIV_RISE);
    assign last_bit = (bit_cnt == BIT_LAST);
    assign bit_nxt  = bit_cnt + 1'b1;

    // Value of the next bit to put on the line once the current bit period ends
    always_comb begin
        pre_next     = (state == PREAMBLE) && (bit_nxt != PRE_END);
        frame_idx    = 5'd31 - 5'(bit_nxt - PRE_END);
        next_bit     = pre_next ? 1'b1 : frame[frame_idx];
        release_next = rd_type && (bit_nxt >= TA_BIT);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (accept) state_next = FIRST;
            PREAMBLE: if (bit_end && (bit_nxt == PRE_END)) state_next = FRAME;
            FRAME:    if (bit_end && last_bit) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt  <= '0;
            div_cnt  <= '0;
            frame    <= '0;
            rd_type  <= 1'b0;
            shift    <= '0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            err      <= 1'b0;
            mdc      <= 1'b0;
            mdio_out <= 1'b0;
            mdio_oe  <= 1'b0;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            err      <= reject;
            if (state == IDLE) begin
                if (accept) begin
                    frame    <= t_data;
                    rd_type  <= rd_in;
                    bit_cnt  <= '0;
                    div_cnt  <= '0;
                    shift    <= '0;
                    mdc      <= 1'b0;
                    mdio_oe  <= 1'b1;
                    mdio_out <= HAS_PRE | t_data[31];
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
                if (mdc_rise) begin
                    mdc <= 1'b1;
                    // PHY data is sampled on the MDC rising edge
                    if (rd_type && (bit_cnt >= DATA_BIT))
                        shift <= {shift[14:0], mdio_in};
                end
                if (bit_end) begin
                    div_cnt <= '0;
                    mdc     <= 1'b0;
                    if (last_bit) begin
                        done     <= 1'b1;
                        mdio_oe  <= 1'b0;
                        mdio_out <= 1'b0;
                        if (rd_type) begin
                            rd_data  <= shift;
                            rd_valid <= 1'b1;
                        end
                    end else begin
                        bit_cnt  <= bit_nxt;
                        mdio_oe  <= !release_next;
                        mdio_out <= release_next ? 1'b0 : next_bit;
                    end
                end
            end
        end
    end

endmodule
